store_buffer: RTL and testbench

Posted-write buffer between the datapath's memory-access stage and the data memory (DM). Stores are queued in a small FIFO and retired into DM one per cycle, in cycles the load path does not need the DM port. Loads get the port combinationally with priority. A load is stalled when it hits a pending store's word or when the buffer is full. This keeps DM strictly in-order and never forwards partial data.

---
 rtl/store_buffer.sv | 99 +++++++++
 tb/tb_store_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of the data memory port.
// Loads take the DM port first. Buffered stores retire in order whenever the port is free.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             St_Valid,
    input  logic [31:0]      St_Adr,
    input  logic [31:0]      St_Data,
    input  logic [1:0]       St_Bop,
    output logic             St_Ready,
    input  logic             Ld_Req,
    input  logic [31:0]      Ld_Adr,
    input  logic [1:0]       Ld_Bop,
    output logic             Ld_Stall,
    output logic             DM_WrEn,
    output logic [31:0]      DM_Adr,
    output logic [31:0]      DM_DataIn,
    output logic [1:0]       DM_Bop,
    output logic [PTR_W:0]   Count,
    output logic             Empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      adr_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [1:0]       bop_q  [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic [DEPTH-1:0] hit;
    logic             full;
    logic             hazard;
    logic             drain;
    logic             enq;

    assign full     = (count_q == FULL_CNT);
    assign St_Ready = !full;
    assign enq      = St_Valid && !full;
    assign Count    = count_q;
    assign Empty    = (count_q == '0);

    // An entry is live when its distance from head is below the count.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = ({1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q) &&
                     (adr_q[i][11:2] == Ld_Adr[11:2]);
        end
    end

    assign hazard   = Ld_Req && (|hit);
    assign drain    = (count_q != '0) && (!Ld_Req || hazard || full);
    assign Ld_Stall = Ld_Req && (hazard || full);
    assign count_d  = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(drain);

    always_comb begin
        DM_WrEn   = 1'b0;
        DM_Adr    = Ld_Adr;
        DM_DataIn = 32'h0;
        DM_Bop    = Ld_Bop;
        if (drain) begin
            DM_WrEn   = 1'b1;
            DM_Adr    = adr_q[head_q];
            DM_DataIn = data_q[head_q];
            DM_Bop    = bop_q[head_q];
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (drain) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset; liveness comes from the pointers and count.
    always_ff @(posedge Clk) begin
        if (enq) begin
            adr_q[tail_q]  <= St_Adr;
            data_q[tail_q] <= St_Data;
            bop_q[tail_q]  <= St_Bop;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a DM model fed by the DUT's write port,
// an in-order store scoreboard, a vector table and hand-written corner sequences.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             St_Valid;
    logic [31:0]      St_Adr;
    logic [31:0]      St_Data;
    logic [1:0]       St_Bop;
    logic             St_Ready;
    logic             Ld_Req;
    logic [31:0]      Ld_Adr;
    logic [1:0]       Ld_Bop;
    logic             Ld_Stall;
    logic             DM_WrEn;
    logic [31:0]      DM_Adr;
    logic [31:0]      DM_DataIn;
    logic [1:0]       DM_Bop;
    logic [PTR_W:0]   Count;
    logic             Empty;

    store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .Clk(Clk), .Rst(Rst),
        .St_Valid(St_Valid), .St_Adr(St_Adr), .St_Data(St_Data), .St_Bop(St_Bop),
        .St_Ready(St_Ready),
        .Ld_Req(Ld_Req), .Ld_Adr(Ld_Adr), .Ld_Bop(Ld_Bop), .Ld_Stall(Ld_Stall),
        .DM_WrEn(DM_WrEn), .DM_Adr(DM_Adr), .DM_DataIn(DM_DataIn), .DM_Bop(DM_Bop),
        .Count(Count), .Empty(Empty)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        logic [1:0]  bop;
        logic [31:0] exp_word;
    } vec_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        logic [1:0]  bop;
    } st_t;

    st_t         sb[$];
    st_t         exp_st;
    logic [31:0] mem [1024] = '{default: 32'h0};
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // DM read as the memory would answer it, addressed by the DUT's port.
    function automatic logic [31:0] ld_val(input logic [31:0] a, input logic [1:0] b);
        logic [31:0] w;
        logic [7:0]  by;
        w  = mem[a[11:2]];
        by = w[8*a[1:0] +: 8];
        case (b)
            2'b10:   return {24'h0, by};
            2'b11:   return {{24{by[7]}}, by};
            default: return w;
        endcase
    endfunction

    // Outputs are stable at the falling edge and describe what the next rising edge commits.
    always @(negedge Clk) begin
        if (Rst) begin
            sb.delete();
        end else begin
            if (DM_WrEn) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_spurious_write: got write to %h, expected no write", DM_Adr);
                end else begin
                    exp_st = sb.pop_front();
                    chk("sb_adr", DM_Adr, exp_st.adr);
                    chk("sb_data", DM_DataIn, exp_st.data);
                    chk("sb_bop", 32'(DM_Bop), 32'(exp_st.bop));
                end
                if (DM_Bop[1]) mem[DM_Adr[11:2]][8*DM_Adr[1:0] +: 8] <= DM_DataIn[7:0];
                else           mem[DM_Adr[11:2]] <= DM_DataIn;
            end
            if (St_Valid && St_Ready) sb.push_back('{St_Adr, St_Data, St_Bop});
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] b);
        St_Valid = 1'b1;
        St_Adr   = a;
        St_Data  = d;
        St_Bop   = b;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (!Empty && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(Empty), 32'd1);
    endtask

    initial begin
        tbl[0] = '{32'h10, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF};
        tbl[1] = '{32'h21, 32'h000000AB, 2'b10, 32'h0000AB00};
        tbl[2] = '{32'h22, 32'h12345678, 2'b11, 32'h0078AB00};
        tbl[3] = '{32'h33, 32'h000000FF, 2'b10, 32'hFF000000};
        tbl[4] = '{32'h44, 32'hCAFEF00D, 2'b00, 32'hCAFEF00D};

        Rst = 1'b1; St_Valid = 1'b0; St_Adr = '0; St_Data = '0; St_Bop = '0;
        Ld_Req = 1'b0; Ld_Adr = 32'h40; Ld_Bop = 2'b00;
        #2;
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_empty", 32'(Empty), 32'd1);
        chk("rst_st_ready", 32'(St_Ready), 32'd1);
        chk("rst_ld_stall", 32'(Ld_Stall), 32'd0);
        chk("rst_dm_wren", 32'(DM_WrEn), 32'd0);
        chk("rst_dm_adr", DM_Adr, 32'h40);
        step();
        Rst = 1'b0;
        step();

        // Single stores, one at a time, no loads.
        for (int i = 0; i < 5; i++) begin
            store(tbl[i].adr, tbl[i].data, tbl[i].bop);
            #1;
            chk("vec_st_ready", 32'(St_Ready), 32'd1);
            chk("vec_no_wr_before", 32'(DM_WrEn), 32'd0);
            step();
            St_Valid = 1'b0;
            #1;
            chk("vec_count1", 32'(Count), 32'd1);
            chk("vec_wren", 32'(DM_WrEn), 32'd1);
            chk("vec_dm_adr", DM_Adr, tbl[i].adr);
            chk("vec_dm_bop", 32'(DM_Bop), 32'(tbl[i].bop));
            step();
            chk("vec_count0", 32'(Count), 32'd0);
            chk("vec_mem_word", mem[tbl[i].adr[11:2]], tbl[i].exp_word);
        end

        // Fill under an unrelated load, then full stall.
        Ld_Req = 1'b1; Ld_Adr = 32'h100; Ld_Bop = 2'b00;
        for (int i = 0; i < 4; i++) begin
            store(32'(4 * i), 32'h1000 + 32'(i), 2'b00);
            #1;
            chk("fill_no_stall", 32'(Ld_Stall), 32'd0);
            chk("fill_no_drain", 32'(DM_WrEn), 32'd0);
            step();
        end
        store(32'h500, 32'h5555, 2'b00);  // offered while full: must be ignored
        #1;
        chk("full_count", 32'(Count), 32'd4);
        chk("full_st_ready", 32'(St_Ready), 32'd0);
        chk("full_ld_stall", 32'(Ld_Stall), 32'd1);
        chk("full_drain", 32'(DM_WrEn), 32'd1);
        chk("full_dm_adr", DM_Adr, 32'h0);
        step();
        St_Valid = 1'b0;
        #1;
        chk("after_full_count", 32'(Count), 32'd3);
        chk("after_full_stall", 32'(Ld_Stall), 32'd0);
        chk("after_full_wren", 32'(DM_WrEn), 32'd0);
        chk("after_full_ld_adr", DM_Adr, 32'h100);
        Ld_Req = 1'b0;
        wait_empty("fill_drain_done", 10);
        for (int i = 0; i < 4; i++) chk("fill_mem", mem[i], 32'h1000 + 32'(i));
        chk("full_store_dropped", mem[32'h500 >> 2], 32'h0);

        // Read-after-write hazard on a pending byte store.
        store(32'h21, 32'h000000AB, 2'b10);
        step();
        St_Valid = 1'b0;
        Ld_Req = 1'b1; Ld_Adr = 32'h20; Ld_Bop = 2'b10;
        #1;
        chk("raw_stall", 32'(Ld_Stall), 32'd1);
        chk("raw_drain", 32'(DM_WrEn), 32'd1);
        chk("raw_dm_adr", DM_Adr, 32'h21);
        step();
        chk("raw_released", 32'(Ld_Stall), 32'd0);
        chk("raw_ld_wren", 32'(DM_WrEn), 32'd0);
        chk("raw_ld_bop", 32'(DM_Bop), 32'(2'b10));
        chk("raw_lbu_20", ld_val(DM_Adr, DM_Bop), 32'h0);
        Ld_Adr = 32'h21;
        #1;
        chk("raw_lbu_21", ld_val(DM_Adr, DM_Bop), 32'hAB);
        Ld_Adr = 32'h33; Ld_Bop = 2'b11;
        #1;
        chk("lb_sign_ext", ld_val(DM_Adr, DM_Bop), 32'hFFFFFFFF);

        // Hazard is word-granular: other word proceeds, other byte of same word stalls.
        Ld_Req = 1'b0;
        store(32'h21, 32'h000000AB, 2'b10);
        step();
        St_Valid = 1'b0;
        Ld_Req = 1'b1; Ld_Adr = 32'h24; Ld_Bop = 2'b00;
        #1;
        chk("other_word_stall", 32'(Ld_Stall), 32'd0);
        chk("other_word_adr", DM_Adr, 32'h24);
        Ld_Adr = 32'h23;
        #1;
        chk("same_word_stall", 32'(Ld_Stall), 32'd1);
        Ld_Req = 1'b0;
        wait_empty("hazard_drain_done", 10);

        // Simultaneous enqueue and dequeue across a pointer wrap.
        Ld_Req = 1'b1; Ld_Adr = 32'h200;
        for (int k = 0; k < 2; k++) begin
            store(32'h80 + 32'(4 * k), 32'hA0 + 32'(k), 2'b00);
            step();
        end
        Ld_Req = 1'b0;
        for (int k = 2; k < 6; k++) begin
            store(32'h80 + 32'(4 * k), 32'hA0 + 32'(k), 2'b00);
            #1;
            chk("enqdeq_wren", 32'(DM_WrEn), 32'd1);
            step();
            chk("enqdeq_count", 32'(Count), 32'd2);
        end
        St_Valid = 1'b0;
        wait_empty("wrap_drain_done", 10);
        for (int k = 0; k < 6; k++) chk("wrap_mem", mem[32'h20 + k], 32'hA0 + 32'(k));

        // Reset while stores are draining discards them.
        Ld_Req = 1'b1; Ld_Adr = 32'h200;
        for (int k = 0; k < 3; k++) begin
            store(32'h300 + 32'(4 * k), 32'h77, 2'b00);
            step();
        end
        St_Valid = 1'b0;
        Ld_Req = 1'b0;
        #1;
        chk("pre_rst_count", 32'(Count), 32'd3);
        chk("pre_rst_wren", 32'(DM_WrEn), 32'd1);
        Rst = 1'b1;
        #1;
        chk("mid_rst_wren", 32'(DM_WrEn), 32'd0);
        chk("mid_rst_count", 32'(Count), 32'd0);
        chk("mid_rst_empty", 32'(Empty), 32'd1);
        step();
        Rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_wren", 32'(DM_WrEn), 32'd0);
        end
        for (int k = 0; k < 3; k++) chk("post_rst_mem", mem[32'hC0 + k], 32'h0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
